// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : calc_pkg
// Purpose  : Shared operator encodings, range limit and FSM state type for
//            the calculator arithmetic engine.
// Revision : 1.0 - initial release
// ============================================================================
package calc_pkg;

    localparam logic [2:0] ARITH_ADD = 3'b000;
    localparam logic [2:0] ARITH_SUB = 3'b001;
    localparam logic [2:0] ARITH_MUL = 3'b010;
    localparam logic [2:0] ARITH_DIV = 3'b011;
    localparam logic [2:0] ARITH_EQ  = 3'b100;

    localparam int unsigned MAX_VAL_DEFAULT = 99_999_999;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/calc_engine_seq_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : seq_muldiv
// Purpose  : Iterative shift-add multiplier / restoring divider, one bit per
//            cycle. The start cycle performs the first iteration.
// Revision : 1.0 - initial release
// ============================================================================
module seq_muldiv #(
    parameter int WIDTH = 27
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     quotient
);
    localparam int         PW     = 2 * WIDTH;
    localparam logic [4:0] C_LAST = 5'(WIDTH - 1);

    // hi: product accumulator (mul) or partial remainder (div)
    // lo: multiplier shifting right (mul) or dividend/quotient shifting left (div)
    // bq: multiplicand shifting left (mul) or fixed divisor (div)
    logic [PW-1:0]    r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [PW-1:0]    r_bq;
    logic             r_div;
    logic             r_run;
    logic             r_done;
    logic [4:0]       r_cnt;

    logic [PW-1:0]    w_src_hi;
    logic [WIDTH-1:0] w_src_lo;
    logic [PW-1:0]    w_src_bq;
    logic             w_src_div;
    logic [PW-1:0]    w_trial;
    logic             w_ge;
    logic [PW-1:0]    w_nxt_hi;
    logic [WIDTH-1:0] w_nxt_lo;
    logic [PW-1:0]    w_nxt_bq;

    always_comb begin
        w_src_hi  = r_hi;
        w_src_lo  = r_lo;
        w_src_bq  = r_bq;
        w_src_div = r_div;
        if (start) begin
            w_src_hi  = '0;
            w_src_lo  = op ? a : b;
            w_src_bq  = PW'(op ? b : a);
            w_src_div = op;
        end

        w_trial  = {w_src_hi[PW-2:0], w_src_lo[WIDTH-1]};
        w_ge     = (w_trial >= w_src_bq);
        w_nxt_hi = w_src_hi;
        w_nxt_lo = w_src_lo;
        w_nxt_bq = w_src_bq;
        if (w_src_div) begin
            w_nxt_hi = w_ge ? (w_trial - w_src_bq) : w_trial;
            w_nxt_lo = {w_src_lo[WIDTH-2:0], w_ge};
        end else begin
            w_nxt_hi = w_src_hi + (w_src_lo[0] ? w_src_bq : '0);
            w_nxt_lo = w_src_lo >> 1;
            w_nxt_bq = w_src_bq << 1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_bq   <= '0;
            r_div  <= 1'b0;
            r_run  <= 1'b0;
            r_done <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_hi  <= w_nxt_hi;
                r_lo  <= w_nxt_lo;
                r_bq  <= w_nxt_bq;
                r_div <= w_src_div;
                r_cnt <= 5'd1;
                r_run <= 1'b1;
            end else if (r_run) begin
                r_hi  <= w_nxt_hi;
                r_lo  <= w_nxt_lo;
                r_bq  <= w_nxt_bq;
                r_cnt <= r_cnt + 5'd1;
                if (r_cnt == C_LAST) begin
                    r_run  <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign done     = r_done;
    assign product  = r_hi;
    assign quotient = r_lo;

endmodule
`default_nettype wire

// File: rtl/calc_engine.sv
`default_nettype none
// ============================================================================
// Module   : calc_engine
// Purpose  : Calculator arithmetic responder: add/sub/equals in one cycle,
//            mul/div iteratively, range check and busy handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module calc_engine
    import calc_pkg::*;
#(
    parameter int          WIDTH   = 27,
    parameter int unsigned MAX_VAL = MAX_VAL_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic [2:0]       arith,
    input  logic             en,
    input  logic             busy_p,
    output logic             busy_a,
    output logic [WIDTH-1:0] result,
    output logic             neg,
    output logic             err,
    output logic             res_valid
);
    localparam int            PW    = 2 * WIDTH;
    localparam logic [PW-1:0] C_MAX = PW'(MAX_VAL);

    state_t           r_state;
    logic             r_en_d;
    logic [WIDTH-1:0] r_d1;
    logic [WIDTH-1:0] r_d2;
    logic [2:0]       r_op;

    logic             w_rise;
    logic             w_md_start;
    logic             w_md_done;
    logic [PW-1:0]    w_product;
    logic [WIDTH-1:0] w_quotient;
    logic             w_iter;
    logic             w_ready;
    logic [PW-1:0]    w_raw;
    logic             w_neg;
    logic             w_bad;
    logic             w_err;

    assign w_rise     = en & ~r_en_d;
    // The engine starts on the capture edge so its 27 iterations end on time
    assign w_md_start = (r_state == S_IDLE) && w_rise &&
                        ((arith == ARITH_MUL) || ((arith == ARITH_DIV) && (data2 != '0)));
    assign w_iter     = (r_op == ARITH_MUL) || ((r_op == ARITH_DIV) && (r_d2 != '0));
    assign w_ready    = ~w_iter | w_md_done;

    seq_muldiv #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .start    (w_md_start),
        .op       (arith == ARITH_DIV),
        .a        (data1),
        .b        (data2),
        .done     (w_md_done),
        .product  (w_product),
        .quotient (w_quotient)
    );

    always_comb begin
        w_raw = '0;
        w_neg = 1'b0;
        w_bad = 1'b0;
        case (r_op)
            ARITH_ADD: w_raw = PW'(r_d1) + PW'(r_d2);
            ARITH_SUB: begin
                if (r_d1 < r_d2) begin
                    w_raw = PW'(r_d2 - r_d1);
                    w_neg = 1'b1;
                end else begin
                    w_raw = PW'(r_d1 - r_d2);
                end
            end
            ARITH_MUL: w_raw = w_product;
            ARITH_DIV: begin
                if (r_d2 == '0) w_bad = 1'b1;
                else            w_raw = PW'(w_quotient);
            end
            ARITH_EQ:  w_raw = PW'(r_d1);
            default:   w_bad = 1'b1;
        endcase
        w_err = w_bad | (w_raw > C_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_en_d    <= 1'b0;
            r_d1      <= '0;
            r_d2      <= '0;
            r_op      <= '0;
            busy_a    <= 1'b0;
            result    <= '0;
            neg       <= 1'b0;
            err       <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            r_en_d    <= en;
            res_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_rise) begin
                        r_d1    <= data1;
                        r_d2    <= data2;
                        r_op    <= arith;
                        busy_a  <= 1'b1;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (w_ready) begin
                        result  <= w_err ? '0 : w_raw[WIDTH-1:0];
                        neg     <= ~w_err & w_neg;
                        err     <= w_err;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!busy_p) begin
                        res_valid <= 1'b1;
                        busy_a    <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_calc_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_engine
// Purpose  : Scoreboard bench for calc_engine with directed transactions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_calc_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [26:0] data1 = '0;
    logic [26:0] data2 = '0;
    logic [2:0]  arith = '0;
    logic        en = 1'b0;
    logic        busy_p = 1'b0;
    logic        busy_a;
    logic [26:0] result;
    logic        neg;
    logic        err;
    logic        res_valid;

    typedef struct {
        logic [26:0] res;
        logic        neg;
        logic        err;
        int          t0;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    calc_engine dut (
        .clk       (clk),
        .rst       (rst),
        .data1     (data1),
        .data2     (data2),
        .arith     (arith),
        .en        (en),
        .busy_p    (busy_p),
        .busy_a    (busy_a),
        .result    (result),
        .neg       (neg),
        .err       (err),
        .res_valid (res_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (res_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_res_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", longint'(result), longint'(e.res));
                check("neg", longint'(neg), longint'(e.neg));
                check("err", longint'(err), longint'(e.err));
                check("latency", cyc - e.t0, e.lat);
            end
        end
    end

    // Drives one transaction, optionally stretching DONE with busy_p and
    // raising en again while busy to confirm it is ignored.
    task automatic issue(input logic [26:0] a, input logic [26:0] b, input logic [2:0] op,
                         input logic [26:0] eres, input logic eneg, input logic eerr,
                         input int lat, input int hold, input bit poke);
        exp_t e;
        int   k;
        int   n;
        @(negedge clk);
        data1  = a;
        data2  = b;
        arith  = op;
        en     = 1'b1;
        busy_p = (hold > 0);
        e.res  = eres;
        e.neg  = eneg;
        e.err  = eerr;
        e.t0   = cyc + 1;
        e.lat  = lat + hold;
        sb.push_back(e);
        k = 0;
        n = 0;
        do begin
            @(negedge clk);
            k++;
            en     = poke && (k >= 4);
            busy_p = (hold > 0) && (k < lat + hold);
            if (busy_a) n++;
        end while (busy_a && k < 300);
        if (k >= 300) check("busy_timeout", k, 0);
        check("busy_cycles", n, lat + hold);
        if (poke) begin
            @(negedge clk);
            en = 1'b0;
        end
        busy_p = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_result", longint'(result), 0);
        check("reset_neg", longint'(neg), 0);
        check("reset_err", longint'(err), 0);
        check("reset_valid", longint'(res_valid), 0);
        check("reset_busy_a", longint'(busy_a), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        issue(27'd12345678, 27'd87654321, 3'b000, 27'd99999999, 1'b0, 1'b0, 2, 0, 1'b0);
        issue(27'd5,        27'd9,        3'b001, 27'd4,        1'b1, 1'b0, 2, 0, 1'b0);
        issue(27'd99999999, 27'd1,        3'b000, 27'd0,        1'b0, 1'b1, 2, 0, 1'b0);
        issue(27'd9,        27'd5,        3'b001, 27'd4,        1'b0, 1'b0, 2, 0, 1'b0);
        issue(27'd9999,     27'd9999,     3'b010, 27'd99980001, 1'b0, 1'b0, 28, 0, 1'b0);
        issue(27'd10000,    27'd10000,    3'b010, 27'd0,        1'b0, 1'b1, 28, 0, 1'b0);
        issue(27'd100,      27'd7,        3'b011, 27'd14,       1'b0, 1'b0, 28, 0, 1'b0);
        issue(27'd5,        27'd0,        3'b011, 27'd0,        1'b0, 1'b1, 2, 0, 1'b0);
        issue(27'd5,        27'd3,        3'b110, 27'd0,        1'b0, 1'b1, 2, 0, 1'b0);
        issue(27'd42,       27'd77,       3'b100, 27'd42,       1'b0, 1'b0, 2, 0, 1'b0);
        issue(27'd11,       27'd22,       3'b000, 27'd33,       1'b0, 1'b0, 2, 10, 1'b1);
        issue(27'd99999999, 27'd99999999, 3'b011, 27'd1,        1'b0, 1'b0, 28, 0, 1'b0);

        // Reset in the middle of a multiply: no expected entry is queued
        @(negedge clk);
        data1 = 27'd1234;
        data2 = 27'd5678;
        arith = 3'b010;
        en    = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (9) @(negedge clk);
        check("abort_busy_before", longint'(busy_a), 1);
        rst = 1'b1;
        #1;
        check("abort_result", longint'(result), 0);
        check("abort_neg", longint'(neg), 0);
        check("abort_err", longint'(err), 0);
        check("abort_valid", longint'(res_valid), 0);
        check("abort_busy_a", longint'(busy_a), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_idle_busy_a", longint'(busy_a), 0);

        issue(27'd3, 27'd4, 3'b000, 27'd7, 1'b0, 1'b0, 2, 0, 1'b0);
        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/calc_engine.md
# calc_engine

Arithmetic responder for the calculator datapath. Accepts the operand/operator transaction produced by the keypad front end (data1, data2, arith, en) and drives busy_a back to it. Computes add, subtract, multiply (iterative) or divide (iterative). Hands the 8-digit result to the display/print stage with a one-cycle valid pulse, gated by that stage's busy_p.

## Interface
Parameters:
- WIDTH, 27, operand and result magnitude width
- MAX_VAL, 99_999_999, largest displayable result; anything above is an error

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- data1  in  WIDTH  first operand, unsigned
- data2  in  WIDTH  second operand, unsigned
- arith  in  3  operator: 000 add, 001 sub, 010 mul, 011 div, 100 equals (pass data1), 101–111 illegal
- en  in  1  transaction strobe, synchronous to clk; a rising edge starts a transaction
- busy_p  in  1  downstream display/print stage busy; result is held while high
- busy_a  out  1  engine busy, high from capture until the result is delivered
- result  out  WIDTH  result magnitude, registered
- neg  out  1  result is negative (subtract only)
- err  out  1  overflow, divide by zero, or illegal operator; result forced to 0
- res_valid  out  1  one-cycle pulse, result/neg/err valid

## Operation
- Reset values: busy_a=0, result=0, neg=0, err=0, res_valid=0, state IDLE, en edge register=0.
- FSM: IDLE → CALC → DONE → IDLE.
- IDLE: on an en rising edge (en=1, previous en=0), capture data1, data2 and arith. Set busy_a=1 and go to CALC.
- CALC, single-cycle operators:
  - add: data1+data2.
  - sub: |data1−data2|, with neg=1 iff data1<data2.
  - equals: result=data1.
  - illegal arith, or div with data2=0: err=1.
  - Each of these goes to DONE after 1 cycle.
- CALC, mul: shift-add, one operand bit per cycle, 27 cycles, 54-bit internal product.
- CALC, div: restoring division, one quotient bit per cycle, 27 cycles. Remainder is discarded.
- Result check: any result > MAX_VAL (including product ≥ 2^27) gives err=1, result=0, neg=0.
- DONE: wait while busy_p=1. On the first edge with busy_p=0: res_valid=1 for one cycle, busy_a=0, go to IDLE.
- result/neg/err stay stable until the next transaction's DONE.
- en edges while busy_a=1 are ignored and are not queued. The edge detector keeps tracking, so a level held across the return to IDLE does not retrigger.
- rst at any point aborts the operation immediately and restores the reset values. No res_valid is emitted.

## Timing
- T0 = edge sampling the en rising edge. busy_a is high after T0.
- add/sub/equals/err cases: DONE after T1, res_valid high in the cycle after T2. Latency is 2 cycles with busy_p=0.
- mul/div: DONE after T27, res_valid after T28. Latency is 28 cycles.
- busy_p high in DONE stretches latency one cycle per busy cycle. busy_p is ignored in IDLE and CALC.
- busy_a falls on the same edge that raises res_valid. The earliest next capture is the edge after that.

## Structure
- Package calc_pkg holds:
  - arith encoding constants (ARITH_ADD, ARITH_SUB, ARITH_MUL, ARITH_DIV, ARITH_EQ)
  - the default MAX_VAL
  - the FSM state enum
- Sub-module seq_muldiv holds the iterative engine. Its ports:
  - inputs: start, op (mul/div), a, b
  - outputs: done, product[2*WIDTH-1:0], quotient
  - it is shared by mul and div and owns the 5-bit iteration counter.
- Top level holds: en edge detector, operand capture, add/sub path, range check, FSM, output registers.

## Test plan
- Add: data1=12345678, data2=87654321, arith=000, en pulse → res_valid 2 cycles later, result=99999999, err=0, neg=0.
- Sub: data1=5, data2=9, arith=001 → result=4, neg=1. Add 99999999+1 → err=1, result=0.
- Mul: 9999×9999 → result=99980001 at latency 28, busy_a high for 28 cycles. Mul 10000×10000 → err=1.
- Div: 100/7 → result=14 at latency 28. Div 5/0 → err=1 at latency 2. arith=110 → err=1.
- Handshake: hold busy_p=1 for 10 cycles in DONE → res_valid delayed exactly 10 cycles, busy_a held. An en pulse during busy_a is ignored.
- Reset: assert rst at cycle 10 of a multiply → all outputs 0 immediately, no res_valid. The next add completes normally.
